// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-control bundle between the CSR unit, EXE stage and imem port.
// PC_FETCH_CTRL_PERF_EN adds the performance counter outputs.
interface pc_fetch_ctrl_if #(
  parameter int XLEN = 32
);
  logic            csr_new_pc_req;
  logic [XLEN-1:0] csr_new_pc;
  logic            exe_new_pc_req;
  logic [XLEN-1:0] exe_new_pc;
  logic            wfi_req;
  logic            irq_wakeup;
  logic            fetch_ready;
  logic [XLEN-1:0] pc_ff;
  logic [XLEN-1:0] pc_next;
  logic            fetch_valid;
  logic            flush_if_id;
  logic            flush_id_exe;
  logic            sleeping;
`ifdef PC_FETCH_CTRL_PERF_EN
  logic [31:0]     perf_redirects;
  logic [31:0]     perf_sleep_cycles;
`endif

  modport master (
    input  csr_new_pc_req, csr_new_pc,
    input  exe_new_pc_req, exe_new_pc,
    input  wfi_req, irq_wakeup, fetch_ready,
    output pc_ff, pc_next, fetch_valid,
    output flush_if_id, flush_id_exe, sleeping
`ifdef PC_FETCH_CTRL_PERF_EN
    , output perf_redirects, perf_sleep_cycles
`endif
  );

  modport slave (
    output csr_new_pc_req, csr_new_pc,
    output exe_new_pc_req, exe_new_pc,
    output wfi_req, irq_wakeup, fetch_ready,
    input  pc_ff, pc_next, fetch_valid,
    input  flush_if_id, flush_id_exe, sleeping
`ifdef PC_FETCH_CTRL_PERF_EN
    , input perf_redirects, perf_sleep_cycles
`endif
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC sequencer: redirect arbitration, busy-imem hold, WFI sleep.
// PC_FETCH_CTRL_PERF_EN adds redirect and sleep-cycle counters.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input logic           clk,
  input logic           rst,
  pc_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {RUN, HOLD, SLEEP} state_t;
  typedef enum logic {SRC_CSR, SRC_EXE} src_t;

  state_t          state_q, state_d;
  src_t            src_q, src_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic [XLEN-1:0] csr_tgt, exe_tgt, pc_plus_4;
  logic            fv, fif, fie, slp, redir;

  assign csr_tgt   = {bus.csr_new_pc[XLEN-1:2], 2'b00};
  assign exe_tgt   = {bus.exe_new_pc[XLEN-1:2], 2'b00};
  assign pc_plus_4 = pc_q + XLEN'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      src_q   <= SRC_CSR;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    fv      = 1'b0;
    fif     = 1'b0;
    fie     = 1'b0;
    slp     = 1'b0;
    redir   = 1'b0;
    unique case (state_q)
      RUN: begin
        fv = 1'b1;
        if (bus.csr_new_pc_req || bus.exe_new_pc_req) begin
          fif   = 1'b1;
          fie   = 1'b1;
          redir = 1'b1;
          if (bus.fetch_ready) begin
            pc_d = bus.csr_new_pc_req ? csr_tgt : exe_tgt;
          end else begin
            pend_d  = bus.csr_new_pc_req ? csr_tgt : exe_tgt;
            src_d   = bus.csr_new_pc_req ? SRC_CSR : SRC_EXE;
            state_d = HOLD;
          end
        end else if (bus.wfi_req) begin
          pc_d    = csr_tgt;
          fif     = 1'b1;
          state_d = SLEEP;
        end else if (bus.fetch_ready) begin
          pc_d = pc_plus_4;
        end
      end
      HOLD: begin
        // A CSR target outranks any EXE target still pending
        if (bus.csr_new_pc_req) begin
          fif    = 1'b1;
          fie    = 1'b1;
          redir  = 1'b1;
          pend_d = csr_tgt;
          src_d  = SRC_CSR;
        end else if (bus.exe_new_pc_req && src_q == SRC_EXE) begin
          fif    = 1'b1;
          fie    = 1'b1;
          redir  = 1'b1;
          pend_d = exe_tgt;
        end
        if (bus.fetch_ready) begin
          pc_d    = pend_d;
          state_d = RUN;
        end
      end
      SLEEP: begin
        slp = 1'b1;
        if (bus.csr_new_pc_req) begin
          pc_d    = csr_tgt;
          fif     = 1'b1;
          fie     = 1'b1;
          redir   = 1'b1;
          state_d = RUN;
        end else if (bus.irq_wakeup) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign bus.pc_ff        = pc_q;
  assign bus.pc_next      = pc_d;
  assign bus.fetch_valid  = fv;
  assign bus.flush_if_id  = fif;
  assign bus.flush_id_exe = fie;
  assign bus.sleeping     = slp;

`ifdef PC_FETCH_CTRL_PERF_EN
  logic [31:0] redir_cnt_q, sleep_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      redir_cnt_q <= '0;
      sleep_cnt_q <= '0;
    end else begin
      if (redir && redir_cnt_q != '1)
        redir_cnt_q <= redir_cnt_q + 32'd1;
      if (slp && sleep_cnt_q != '1)
        sleep_cnt_q <= sleep_cnt_q + 32'd1;
    end
  end

  assign bus.perf_redirects    = redir_cnt_q;
  assign bus.perf_sleep_cycles = sleep_cnt_q;
`else
  logic unused_redir;
  assign unused_redir = redir;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized bench for pc_fetch_ctrl against a cycle-level reference model.
// PC_FETCH_CTRL_PERF_EN additionally checks the perf counters.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RPC = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_fetch_ctrl_if #(.XLEN(32)) b ();

  pc_fetch_ctrl #(.RESET_PC(RPC), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // reference model: where the PC is, what is pending, whether asleep
  logic [31:0] m_pc;
  bit          m_pend;
  bit          m_pend_csr;
  logic [31:0] m_pend_pc;
  bit          m_sleep;
  int unsigned m_redirs;
  int unsigned m_sleeps;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive(bit c, logic [31:0] cp, bit e, logic [31:0] ep,
                       bit w, bit irq, bit rdy);
    b.csr_new_pc_req = c;
    b.csr_new_pc     = cp;
    b.exe_new_pc_req = e;
    b.exe_new_pc     = ep;
    b.wfi_req        = w;
    b.irq_wakeup     = irq;
    b.fetch_ready    = rdy;
  endtask

  // one clock: check outputs for the driven inputs, then advance the model
  task automatic tick();
    logic [31:0] ct, et, nxt, nppc;
    bit fv, fi, fe, np, nsl, npcsr;
    ct    = b.csr_new_pc & 32'hFFFF_FFFC;
    et    = b.exe_new_pc & 32'hFFFF_FFFC;
    nxt   = m_pc;
    np    = m_pend;
    nsl   = m_sleep;
    nppc  = m_pend_pc;
    npcsr = m_pend_csr;
    fv    = !m_pend && !m_sleep;
    fi    = 1'b0;
    fe    = 1'b0;
    if (m_sleep) begin
      if (b.csr_new_pc_req) begin
        nxt = ct; fi = 1; fe = 1; nsl = 0;
      end else if (b.irq_wakeup) nsl = 0;
    end else if (m_pend) begin
      if (b.csr_new_pc_req) begin
        nppc = ct; npcsr = 1; fi = 1; fe = 1;
      end else if (b.exe_new_pc_req && !m_pend_csr) begin
        nppc = et; fi = 1; fe = 1;
      end
      if (b.fetch_ready) begin
        nxt = nppc; np = 0;
      end
    end else begin
      if (b.csr_new_pc_req || b.exe_new_pc_req) begin
        fi = 1; fe = 1;
        if (b.fetch_ready) nxt = b.csr_new_pc_req ? ct : et;
        else begin
          np = 1;
          nppc = b.csr_new_pc_req ? ct : et;
          npcsr = b.csr_new_pc_req;
        end
      end else if (b.wfi_req) begin
        nxt = ct; fi = 1; nsl = 1;
      end else if (b.fetch_ready) nxt = m_pc + 32'd4;
    end
    #1;
    if (!rst) begin
      check("pc_ff", b.pc_ff, m_pc);
      check("pc_next", b.pc_next, nxt);
      check("fetch_valid", b.fetch_valid, fv);
      check("flush_if_id", b.flush_if_id, fi);
      check("flush_id_exe", b.flush_id_exe, fe);
      check("sleeping", b.sleeping, m_sleep);
`ifdef PC_FETCH_CTRL_PERF_EN
      check("perf_redirects", b.perf_redirects, m_redirs);
      check("perf_sleep_cycles", b.perf_sleep_cycles, m_sleeps);
`endif
    end
    @(posedge clk);
    if (rst) begin
      m_pc = RPC; m_pend = 0; m_sleep = 0; m_pend_csr = 0;
      m_pend_pc = '0; m_redirs = 0; m_sleeps = 0;
    end else begin
      if (fe) m_redirs++;
      if (m_sleep) m_sleeps++;
      m_pc = nxt; m_pend = np; m_sleep = nsl;
      m_pend_pc = nppc; m_pend_csr = npcsr;
    end
    @(negedge clk);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_pc", b.pc_ff, RPC);
    check("rst_fv", b.fetch_valid, 1);
    tick();
    check("seq_pc1", b.pc_ff, 32'h1004);
    tick();
    check("seq_pc2", b.pc_ff, 32'h1008);

    // csr beats exe in the same cycle
    drive(1, 32'h2000, 1, 32'h3000, 0, 0, 1);
    #1;
    check("prio_flush_if", b.flush_if_id, 1);
    check("prio_flush_ex", b.flush_id_exe, 1);
    tick();
    check("prio_pc", b.pc_ff, 32'h2000);

    // exe held while imem busy, then overridden by csr
    drive(0, 0, 1, 32'h4002, 0, 0, 0);
    tick();
    check("hold_fv", b.fetch_valid, 0);
    drive(1, 32'h5000, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    check("hold_pc", b.pc_ff, 32'h5000);

    // wfi sleep for five cycles, irq wake
    drive(0, 32'h6000, 0, 0, 1, 0, 1);
    tick();
    drive(0, 0, 1, 32'h9000, 1, 0, 1);
    for (int i = 0; i < 4; i++) tick();
    check("wfi_sleep", b.sleeping, 1);
    check("wfi_pc", b.pc_ff, 32'h6000);
    check("wfi_fv", b.fetch_valid, 0);
    drive(0, 0, 0, 0, 0, 1, 1);
    tick();
    check("wake_fv", b.fetch_valid, 1);
    check("wake_pc", b.pc_ff, 32'h6000);
`ifdef PC_FETCH_CTRL_PERF_EN
    check("perf_sleep5", b.perf_sleep_cycles, 5);
`endif

    // wraparound
    drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    check("wrap_pc", b.pc_ff, 32'h0);

    // reset while holding a pending target
    drive(0, 0, 1, 32'h7000, 0, 0, 0);
    tick();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    rst = 1'b0;
    check("rst_hold_pc", b.pc_ff, RPC);
    check("rst_hold_fv", b.fetch_valid, 1);
    tick();
    check("rst_hold_seq", b.pc_ff, RPC + 32'd4);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) == 0, $urandom,
            $urandom_range(0, 6) == 0, $urandom,
            $urandom_range(0, 12) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Sequences the fetch program counter for the 32-bit core.
- Owns the pc_ff register and arbitrates the redirect sources: CSR trap/xRET, EXE branch/jump, and WFI.
- Holds a redirect that arrives while instruction memory is busy, and runs the WFI sleep/wake state machine.
- Sits between the CSR unit, the EXE stage and the instruction-memory request port; drives the pipeline flush lines.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into pc_ff on reset.
- XLEN, 32, PC width; only 32 is supported.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- csr_new_pc_req  in  1  CSR redirect request (trap, xRET, WFI resume target valid).
- csr_new_pc  in  32  CSR redirect target.
- exe_new_pc_req  in  1  branch/jump taken in EXE.
- exe_new_pc  in  32  EXE redirect target.
- wfi_req  in  1  WFI retiring; csr_new_pc carries the resume PC in the same cycle.
- irq_wakeup  in  1  any enabled interrupt pending (level).
- fetch_ready  in  1  imem accepts the request at pc_ff this cycle.
- pc_ff  out  32  registered current fetch address.
- pc_next  out  32  combinational next value of pc_ff.
- fetch_valid  out  1  fetch request valid at pc_ff.
- flush_if_id  out  1  kill the IF/ID register.
- flush_id_exe  out  1  kill the ID/EXE register.
- sleeping  out  1  core in WFI sleep.

Behaviour:
- **Reset** (rst=1 at a clk edge):
  - pc_ff=RESET_PC, state=RUN, pend_valid=0.
  - fetch_valid=1 from the first cycle after reset.
  - flush_if_id=flush_id_exe=0, sleeping=0.
  - rst mid-HOLD or mid-SLEEP discards the pending target and the sleep state.
- **Targets**:
  - pc_plus_4 = pc_ff+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - Bits [1:0] of every redirect target are forced to 0.
- **Priority** (per cycle): csr_new_pc_req > exe_new_pc_req > wfi_req > sequential.
- **States**: RUN, HOLD, SLEEP.
- **RUN**:
  - csr req: flush_if_id=flush_id_exe=1 in the same cycle.
    - fetch_ready=1: pc_ff<=csr_new_pc.
    - else: pend_pc<=csr_new_pc, pend_src=CSR, go to HOLD.
  - exe req (no csr req): flush_if_id=1 and flush_id_exe=1.
    - fetch_ready=1: pc_ff<=exe_new_pc.
    - else: latch into pend with pend_src=EXE, go to HOLD.
  - wfi_req alone: pc_ff<=csr_new_pc regardless of fetch_ready; flush_if_id=1; go to SLEEP.
  - none: pc_ff<=pc_plus_4 if fetch_ready, else hold.
- **HOLD**:
  - fetch_valid=0, so no stale-path fetch is issued.
  - New csr req: overwrites pend (pend_src=CSR) and asserts both flushes.
  - New exe req: overwrites pend only if pend_src=EXE; ignored if pend_src=CSR.
  - fetch_ready=1: pc_ff<=pend_pc (or the same-cycle higher-priority target), pend_valid<=0, go to RUN.
  - wfi_req in HOLD is ignored.
- **SLEEP**:
  - sleeping=1, fetch_valid=0, pc_ff held.
  - exe_new_pc_req and wfi_req are ignored.
  - csr req: pc_ff<=csr_new_pc, flush both, go to RUN (next cycle fetch_valid=1).
  - irq_wakeup with no csr req: go to RUN, resuming at the held pc_ff.
  - irq_wakeup high in the WFI entry cycle still enters SLEEP; wake happens next cycle.
- **pc_next**:
  - Equals the value pc_ff takes at the next edge, given the current inputs.
  - Equals pc_ff when holding.
- **Latency**: redirect to the new pc_ff is 1 cycle when fetch_ready=1, otherwise first ready cycle +1.

Optional Feature:
- Macro: PC_FETCH_CTRL_PERF_EN.
- When defined, adds outputs:
  - perf_redirects (32): count of accepted csr+exe redirects, counted once per latch, not per HOLD cycle.
  - perf_sleep_cycles (32): count of cycles with sleeping=1.
  - Both counters saturate at 0xFFFF_FFFF and reset to 0.
- When undefined: the ports and logic are absent.

Test Plan:
- Reset with RESET_PC=0x1000, fetch_ready=1 for 3 cycles -> pc_ff 0x1000, 0x1004, 0x1008; fetch_valid=1.
- csr req=0x2000 and exe req=0x3000 in the same cycle, fetch_ready=1 -> pc_ff=0x2000 next cycle; both flushes=1 in the request cycle.
- exe req=0x4002 with fetch_ready=0 for 2 cycles, csr req=0x5000 in the 2nd cycle, then ready -> pc_ff=0x5000 (bits[1:0] cleared had exe won); fetch_valid=0 during HOLD.
- wfi_req with csr_new_pc=0x6000 -> sleeping=1, pc_ff=0x6000, fetch_valid=0; irq_wakeup after 5 cycles -> RUN, fetch at 0x6000. Under PERF_EN, perf_sleep_cycles=5.
- pc_ff=0xFFFF_FFFC with fetch_ready=1 -> pc_ff=0x0000_0000.
- rst asserted during HOLD (pend=0x7000) -> pc_ff=RESET_PC, pend discarded, state RUN.
